// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, error codes and
// frame layout. Frames are start(0) + 8 data bits LSB first + odd parity + stop(1).
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DPS   = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int FRAME_BITS = 11;

    // Classifies a fully assembled frame; framing errors take priority over parity.
    function automatic logic [1:0] frame_status(input logic [FRAME_BITS-1:0] frame);
        logic [1:0] status;
        status = ERR_NONE;
        if (frame[0] != 1'b0 || frame[FRAME_BITS-1] != 1'b1) begin
            status = ERR_FRAME;
        end else if ((^frame[FRAME_BITS-2:1]) != 1'b1) begin
            status = ERR_PARITY;
        end
        return status;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous show-ahead FIFO holding received bytes. A push into a full
// FIFO is accepted when a pop happens in the same cycle; pops while empty are ignored.
module ps2_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       wr_accept_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign do_pop      = rd_en_i & ~empty_o;
    assign do_push     = wr_en_i & (~full_o | do_pop);
    assign wr_accept_o = do_push;
    assign rd_data_o   = mem_q[rd_ptr_q];

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_chk.sv
// PS/2 device-to-host receiver with glitch-filtered clock, frame checking and
// a byte FIFO. Define PS2_RX_CHK_TIMEOUT_EN to abort frames whose clock stalls
// for TIMEOUT_CYC cycles between falling edges (reported as error code 11).
module ps2_rx_chk
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       rx_done_tick,
    output logic       err_tick,
    output logic [1:0] err_code,
    output logic       overflow
);

    logic [1:0]            ps2d_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  f_ps2c_q, f_ps2c_d;
    logic                  fall_edge;
    state_t                state_q;
    logic [3:0]            n_q;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [1:0]            status_d;
    logic                  good_q, err_tick_q, overflow_q;
    logic [1:0]            err_code_q;
    logic                  timed_out;
    logic                  fifo_wr, fifo_accept;

    // Two-flop synchronizer for the raw data line.
    always_ff @(posedge clk) begin
        if (reset) ps2d_sync_q <= 2'b00;
        else       ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
    end

    // Filtered clock only changes once the whole sample window agrees.
    always_comb begin
        f_ps2c_d = f_ps2c_q;
        if (&filt_q)       f_ps2c_d = 1'b1;
        else if (~|filt_q) f_ps2c_d = 1'b0;
    end

    assign fall_edge = f_ps2c_q & ~f_ps2c_d;

    // Sample window for the PS/2 clock and the filtered clock register.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q   <= '0;
            f_ps2c_q <= 1'b0;
        end else begin
            filt_q   <= {ps2c, filt_q[FILTER_LEN-1:1]};
            f_ps2c_q <= f_ps2c_d;
        end
    end

    assign sr_d     = {ps2d_sync_q[1], sr_q[FRAME_BITS-1:1]};
    assign status_d = frame_status(sr_d);

`ifdef PS2_RX_CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr_q;

    assign timed_out = (state_q == DPS) && !fall_edge && (tmr_q == TW'(TIMEOUT_CYC - 1));

    // Inter-edge watchdog: restarts on every falling edge, runs only mid-frame.
    always_ff @(posedge clk) begin
        if (reset || fall_edge)  tmr_q <= '0;
        else if (state_q == DPS) tmr_q <= tmr_q + 1'b1;
        else                     tmr_q <= '0;
    end
`else
    assign timed_out = 1'b0;
`endif

    // Frame FSM: the verdict is decided on the last edge so the ticks line up with CHECK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= 4'd0;
            sr_q       <= '0;
            good_q     <= 1'b0;
            err_tick_q <= 1'b0;
            err_code_q <= ERR_NONE;
            overflow_q <= 1'b0;
        end else begin
            err_tick_q <= 1'b0;
            err_code_q <= ERR_NONE;
            case (state_q)
                IDLE: begin
                    good_q <= 1'b0;
                    if (fall_edge && rx_en) begin
                        sr_q    <= sr_d;
                        n_q     <= 4'd9;
                        state_q <= DPS;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        sr_q <= sr_d;
                        if (n_q == 4'd0) begin
                            state_q <= CHECK;
                            if (status_d == ERR_NONE) begin
                                good_q <= 1'b1;
                            end else begin
                                err_tick_q <= 1'b1;
                                err_code_q <= status_d;
                            end
                        end else begin
                            n_q <= n_q - 4'd1;
                        end
                    end else if (timed_out) begin
                        state_q    <= IDLE;
                        err_tick_q <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    good_q  <= 1'b0;
                    if (good_q && full && !rd) overflow_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_wr      = (state_q == CHECK) && good_q;
    assign rx_done_tick = fifo_accept;
    assign err_tick     = err_tick_q;
    assign err_code     = err_code_q;
    assign overflow     = overflow_q;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (fifo_wr),
        .wr_data_i   (sr_q[8:1]),
        .rd_en_i     (rd),
        .rd_data_o   (dout),
        .wr_accept_o (fifo_accept),
        .empty_o     (empty),
        .full_o      (full)
    );

endmodule
